multitrack_sram_mixer: RTL and testbench

//  Parametrised multi-track loop player/recorder on the board's async cellular RAM. Successor to the 2-track byte-lane design.

---
 rtl/multitrack_sram_mixer.sv | 200 ++++++++++++++++++++
 tb/tb_multitrack_sram_mixer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multitrack_sram_mixer.sv
// Multi-track loop player/recorder on asynchronous cellular RAM: one optional record write, then reads of every unmuted track per sample tick, summed into one mix.
// Optional feature macro MIX_SATURATE_EN: clamp the mix to 16-bit signed range instead of wrapping.
module multitrack_sram_mixer #(
   parameter int NUM_TRACKS  = 4,
   parameter int ADDR_W      = 18,
   parameter int LOOP_LEN    = 2**18,
   parameter int SAMPLE_DIV  = 3125,
   parameter int WAIT_CYCLES = 6,
   localparam int TRACK_BITS = $clog2(NUM_TRACKS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rec_en,
   input  logic [TRACK_BITS-1:0] rec_track,
   input  logic [15:0]           rec_data,
   input  logic [NUM_TRACKS-1:0] track_mute,
   inout  wire  [15:0]           MemDB,
   output logic [22:0]           MemAdr,
   output logic                  RamAdv,
   output logic                  RamClk,
   output logic                  RamCS,
   output logic                  MemOE,
   output logic                  MemWR,
   output logic                  RamLB,
   output logic                  RamUB,
   output logic [15:0]           mix_out,
   output logic                  mix_valid,
   output logic                  busy,
   output logic                  overrun,
   output logic [ADDR_W-1:0]     loop_addr
);

   localparam int ACC_W  = 16 + TRACK_BITS;
   localparam int CNT_W  = $clog2(SAMPLE_DIV);
   localparam int WAIT_W = $clog2(WAIT_CYCLES);

   localparam logic [6:0] CTRL_INACTIVE = 7'b1111111;
   localparam logic [6:0] CTRL_READ     = 7'b0000100;
   localparam logic [6:0] CTRL_WRITE    = 7'b0001000;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RECOVER,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [CNT_W-1:0]        tick_cnt_reg;
   logic [WAIT_W-1:0]       wait_cnt_reg;
   logic [NUM_TRACKS-1:0]   rd_pend_reg;
   logic                    cur_wr_reg;
   logic [22:0]             adr_reg;
   logic [15:0]             wdata_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic [15:0]             mix_out_reg;
   logic [ADDR_W-1:0]       loop_addr_reg;
   logic                    overrun_reg;

   logic                    tick;
   logic                    accept;
   logic                    rec_ok;
   logic                    access_last;
   logic                    src_wr;
   logic [NUM_TRACKS-1:0]   src_rd;
   logic [NUM_TRACKS-1:0]   first_oh;
   logic [TRACK_BITS-1:0]   rd_trk;
   logic [TRACK_BITS-1:0]   sel_trk;
   logic                    has_next;
   logic                    drive_en;
   logic [6:0]              ctrl_word;
   logic [15:0]             mix_sat;

   assign tick        = (tick_cnt_reg == CNT_W'(SAMPLE_DIV - 1));
   assign accept      = tick && (state_reg == S_IDLE || state_reg == S_DONE);
   assign rec_ok      = rec_en && (32'(rec_track) < NUM_TRACKS);
   assign access_last = (wait_cnt_reg == WAIT_W'(WAIT_CYCLES - 1));

   // Candidate accesses: fresh tick inputs when starting, remaining reads after each recovery.
   // The record write is always first, so it can only be pending at the start.
   assign src_wr = (state_reg == S_RECOVER) ? 1'b0 : rec_ok;
   assign src_rd = (state_reg == S_RECOVER) ? rd_pend_reg : ~track_mute;

   genvar gi;
   for (gi = 0; gi < NUM_TRACKS; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
         assign first_oh[gi] = src_rd[gi];
      end else begin : g_upper
         assign first_oh[gi] = src_rd[gi] & ~(|src_rd[gi-1:0]);
      end
   end

   always_comb begin
      rd_trk = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         if (first_oh[i]) rd_trk = rd_trk | TRACK_BITS'(i);
      end
   end

   assign sel_trk  = src_wr ? rec_track : rd_trk;
   assign has_next = src_wr | (|src_rd);

   always_comb begin
`ifdef MIX_SATURATE_EN
      if (acc_reg > SAT_HI)      mix_sat = 16'h7fff;
      else if (acc_reg < SAT_LO) mix_sat = 16'h8000;
      else                       mix_sat = acc_reg[15:0];
`else
      mix_sat = acc_reg[15:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      ctrl_word  = CTRL_INACTIVE;
      busy       = 1'b0;
      drive_en   = 1'b0;
      mix_valid  = 1'b0;
      case (state_reg)
         S_IDLE, S_DONE: begin
            mix_valid = (state_reg == S_DONE);
            if (tick) state_next = has_next ? S_SETUP : S_DONE;
            else      state_next = S_IDLE;
         end
         S_SETUP: begin
            busy       = 1'b1;
            state_next = S_ACCESS;
         end
         S_ACCESS: begin
            busy      = 1'b1;
            ctrl_word = cur_wr_reg ? CTRL_WRITE : CTRL_READ;
            drive_en  = cur_wr_reg;
            if (access_last) state_next = S_RECOVER;
         end
         S_RECOVER: begin
            busy       = 1'b1;
            state_next = has_next ? S_SETUP : S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_reg  <= '0;
         wait_cnt_reg  <= '0;
         rd_pend_reg   <= '0;
         cur_wr_reg    <= 1'b0;
         adr_reg       <= '0;
         wdata_reg     <= '0;
         acc_reg       <= '0;
         mix_out_reg   <= '0;
         loop_addr_reg <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
         if (tick && busy) overrun_reg <= 1'b1;
         if (accept) begin
            wdata_reg <= rec_data;
            acc_reg   <= '0;
         end
         // Address only moves here, so it is stable through each whole access.
         if (state_next == S_SETUP) begin
            cur_wr_reg  <= src_wr;
            rd_pend_reg <= src_rd & ~(src_wr ? '0 : first_oh);
            adr_reg     <= 23'({sel_trk, loop_addr_reg});
         end
         if (state_reg == S_ACCESS) begin
            if (access_last) begin
               wait_cnt_reg <= '0;
               if (!cur_wr_reg) acc_reg <= acc_reg + ACC_W'($signed(MemDB));
            end else begin
               wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
         end
         if (state_next == S_DONE) begin
            mix_out_reg   <= accept ? 16'h0000 : mix_sat;
            loop_addr_reg <= (loop_addr_reg == ADDR_W'(LOOP_LEN - 1)) ? '0 : loop_addr_reg + 1'b1;
         end
      end
   end

   assign MemDB     = drive_en ? wdata_reg : 16'bz;
   assign MemAdr    = adr_reg;
   assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_word;
   assign mix_out   = mix_out_reg;
   assign overrun   = overrun_reg;
   assign loop_addr = loop_addr_reg;

endmodule

// File: tb/tb_multitrack_sram_mixer.sv
// Bench for multitrack_sram_mixer: pin-level RAM model, array-based reference mix, scoreboard queue checked by a monitor.
module tb_multitrack_sram_mixer;

   localparam int NT  = 2;
   localparam int AW  = 3;
   localparam int LL  = 4;
   localparam int DIV = 40;
   localparam int WC  = 6;
   localparam logic [6:0] C_IDLE  = 7'b1111111;
   localparam logic [6:0] C_READ  = 7'b0000100;
   localparam logic [6:0] C_WRITE = 7'b0001000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          rec_en = 1'b0;
   logic [0:0]    rec_track = 1'b0;
   logic [15:0]   rec_data = 16'h0;
   logic [1:0]    track_mute = 2'b00;
   wire  [15:0]   mem_db;
   logic [22:0]   mem_adr;
   logic          ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub;
   logic [15:0]   mix_out;
   logic          mix_valid, busy, overrun;
   logic [AW-1:0] loop_addr;

   wire  [15:0]   mem_db_o;
   logic [22:0]   mem_adr_o;
   logic          adv_o, rclk_o, cs_o, oe_o, wr_o, lb_o, ub_o;
   logic [15:0]   mix_out_o;
   logic          mix_valid_o, busy_o, overrun_o;
   logic [AW-1:0] loop_addr_o;

   multitrack_sram_mixer #(.NUM_TRACKS(NT), .ADDR_W(AW), .LOOP_LEN(LL), .SAMPLE_DIV(DIV), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst(rst), .rec_en(rec_en), .rec_track(rec_track), .rec_data(rec_data),
      .track_mute(track_mute), .MemDB(mem_db), .MemAdr(mem_adr), .RamAdv(ram_adv), .RamClk(ram_clk),
      .RamCS(ram_cs), .MemOE(mem_oe), .MemWR(mem_wr), .RamLB(ram_lb), .RamUB(ram_ub),
      .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun), .loop_addr(loop_addr));

   multitrack_sram_mixer #(.NUM_TRACKS(NT), .ADDR_W(AW), .LOOP_LEN(LL), .SAMPLE_DIV(10), .WAIT_CYCLES(WC)) u_ovr (
      .clk(clk), .rst(rst), .rec_en(1'b0), .rec_track(1'b0), .rec_data(16'h0),
      .track_mute(2'b00), .MemDB(mem_db_o), .MemAdr(mem_adr_o), .RamAdv(adv_o), .RamClk(rclk_o),
      .RamCS(cs_o), .MemOE(oe_o), .MemWR(wr_o), .RamLB(lb_o), .RamUB(ub_o),
      .mix_out(mix_out_o), .mix_valid(mix_valid_o), .busy(busy_o), .overrun(overrun_o), .loop_addr(loop_addr_o));

   // Pin-level RAM: {track, loop address} selects a word; image is loaded while reset is held.
   logic [15:0] ram [16];
   logic [15:0] init_img [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_img[i];
      end else if (!ram_cs && !mem_wr) begin
         ram[mem_adr[3:0]] <= mem_db;
      end
   end
   assign mem_db   = (!ram_cs && !mem_oe && mem_wr) ? ram[mem_adr[3:0]] : 16'bz;
   assign mem_db_o = (!cs_o && !oe_o) ? 16'h0001 : 16'bz;

   int k;
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   typedef struct {
      logic [15:0]   mix;
      logic [AW-1:0] addr;
      int            cyc;
   } exp_t;
   exp_t sbq[$];

   int total = 0;
   int bad = 0;
   logic signed [15:0] ref_mem [NT][LL];
   int m_addr = 0;
   logic [15:0] exp_wdata = 16'h0;
   logic [22:0] exp_wadr = 23'h0;
   logic chk_en = 1'b1;
   int ovr_cnt = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Wait for the tick cycle, present the inputs and push the model's expected result.
   task automatic do_tick(input logic en, input logic trk, input logic [15:0] data, input logic [1:0] mute);
      int guard = 0;
      int sum = 0;
      int nacc = 0;
      int a;
      exp_t e;
      @(negedge clk);
      while ((k % DIV) != DIV - 1 && guard < 4 * DIV) begin
         @(negedge clk);
         guard++;
      end
      chk("tick_wait_timeout", int'(guard >= 4 * DIV), 0);
      rec_en = en; rec_track = trk; rec_data = data; track_mute = mute;
      a = m_addr;
      if (en) begin
         ref_mem[trk][a] = data;
         nacc++;
         exp_wdata = data;
         exp_wadr  = 23'({trk, 3'(a)});
      end
      for (int t = 0; t < NT; t++) begin
         if (!mute[t]) begin
            sum += int'(ref_mem[t][a]);
            nacc++;
         end
      end
`ifdef MIX_SATURATE_EN
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
`endif
      m_addr = (a + 1) % LL;
      e.mix  = 16'(sum);
      e.addr = AW'(m_addr);
      e.cyc  = k + nacc * (WC + 2) + 1;
      sbq.push_back(e);
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && mix_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("mix_out", int'(mix_out), int'(e.mix));
               chk("loop_addr", int'(loop_addr), int'(e.addr));
               chk("valid_cycle", k, e.cyc);
               chk("busy_on_done", int'(busy), 0);
               $display("tick result mix=%04h addr=%0d cyc=%0d", mix_out, loop_addr, k);
            end
         end
      end
   end

   // RAM pin protocol monitor: one set of checks per access window.
   initial begin
      int run = 0;
      logic [6:0] ctrl, first_ctrl;
      logic [22:0] first_adr;
      logic [15:0] last_db;
      logic moved;
      first_ctrl = C_IDLE; first_adr = '0; last_db = '0; moved = 1'b0;
      forever begin
         @(negedge clk);
         ctrl = {ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub};
         if (!chk_en || rst) begin
            run = 0;
         end else if (ctrl != C_IDLE) begin
            if (run == 0) begin
               first_ctrl = ctrl;
               first_adr  = mem_adr;
               moved      = 1'b0;
            end
            if (mem_adr != first_adr || ctrl != first_ctrl) moved = 1'b1;
            if (ctrl == C_WRITE) last_db = mem_db;
            run++;
         end else if (run > 0) begin
            chk("window_len", run, WC);
            chk("window_word", int'(first_ctrl == C_READ || first_ctrl == C_WRITE), 1);
            chk("window_stable", int'(moved), 0);
            chk("busy_in_recover", int'(busy), 1);
            if (first_ctrl == C_WRITE) begin
               chk("write_data", int'(last_db), int'(exp_wdata));
               chk("write_adr", int'(first_adr), int'(exp_wadr));
            end
            run = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && mix_valid_o) ovr_cnt++;
      end
   end

   // Overrun instance: ticks every 10 cycles, each sequence takes 17, so every other tick drops.
   initial begin
      wait (rst == 1'b0);
      while (k < 18) @(negedge clk);
      chk("ovr_before", int'(overrun_o), 0);
      while (k < 21) @(negedge clk);
      chk("ovr_set", int'(overrun_o), 1);
      while (k < 110) @(negedge clk);
      chk("ovr_sticky", int'(overrun_o), 1);
      chk("ovr_completed", ovr_cnt, 5);
      chk("ovr_loop_addr", int'(loop_addr_o), 1);
      chk("ovr_mix", int'(mix_out_o), 2);
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int guard;
      for (int t = 0; t < NT; t++)
         for (int a = 0; a < LL; a++) ref_mem[t][a] = 16'($urandom_range(0, 65535));
      ref_mem[0][0] = 16'sd100;
      ref_mem[1][0] = -16'sd30;
      ref_mem[0][1] = 16'sd0;
      ref_mem[0][2] = 16'sd30000;
      ref_mem[1][2] = 16'sd30000;
      for (int i = 0; i < 16; i++) init_img[i] = 16'h0;
      for (int t = 0; t < NT; t++)
         for (int a = 0; a < LL; a++) init_img[t * 8 + a] = ref_mem[t][a];

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ctrl", int'({ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub}), int'(C_IDLE));
      chk("rst_mix_out", int'(mix_out), 0);
      chk("rst_mix_valid", int'(mix_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_loop_addr", int'(loop_addr), 0);

      do_tick(1'b0, 1'b0, 16'h0000, 2'b00);
      do_tick(1'b1, 1'b1, 16'h1234, 2'b00);
      do_tick(1'b0, 1'b0, 16'h0000, 2'b00);
      do_tick(1'b0, 1'b0, 16'h0000, 2'b11);
      do_tick(1'b0, 1'b0, 16'h0000, 2'b00);
      for (int n = 0; n < 30; n++)
         do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 2'($urandom_range(0, 3)));

      guard = 0;
      while (sbq.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", sbq.size(), 0);

      // Reset in the middle of a write access.
      chk_en = 1'b0;
      do_tick(1'b1, 1'b0, 16'hA5A5, 2'b11);
      guard = 0;
      while (ram_cs != 1'b0 && guard < 4 * DIV) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      chk("pre_rst_drive", int'(mem_db == 16'hA5A5), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", int'({ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub}), int'(C_IDLE));
      chk("mid_rst_bus", int'(mem_db == 16'hA5A5), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(mix_valid), 0);
      chk("mid_rst_mix", int'(mix_out), 0);
      chk("mid_rst_addr", int'(loop_addr), 0);
      chk("mid_rst_ovr_clear", int'(overrun_o), 0);
      sbq.delete();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_overrun", int'(overrun), 0);
      chk("post_rst_busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
